// File: rtl/md5_digit_core.sv
// md5_digit_core: MD5 of a single 8-byte message.
//
// The message is padded into one 512-bit block (0x80 terminator, 64-bit length = 64), the 64 MD5
// rounds run UNROLL per clock, and the chaining values are folded back into the digest.
//
// Ports
//   clk     : single clock, rising edge
//   reset_n : synchronous active-low reset
//   start   : request pulse, accepted in idle or in the done cycle
//   msg     : 8 ASCII bytes, msg[63:56] is the first character
//   busy    : high while rounds are being evaluated
//   done    : one-cycle pulse, digest valid
//   digest  : MD5 digest, digest[127:120] is the leftmost printed hex pair
module md5_digit_core #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [63:0]  msg,
    output logic         busy,
    output logic         done,
    output logic [127:0] digest
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : gen_unroll_check
        $error("md5_digit_core: UNROLL must be 1, 2 or 4");
    end

    localparam logic [31:0] InitA = 32'h67452301;
    localparam logic [31:0] InitB = 32'hefcdab89;
    localparam logic [31:0] InitC = 32'h98badcfe;
    localparam logic [31:0] InitD = 32'h10325476;

    // Counter value at which the final group of rounds is evaluated.
    localparam logic [5:0] LastRnd = 6'(64 - UNROLL);

    localparam logic [31:0] KTab [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {round group, round mod 4}.
    localparam logic [4:0] STab [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinish
    } state_e;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] md5_f(input logic [1:0] grp, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        unique case (grp)
            2'd0:    r = (b & c) | (~b & d);
            2'd1:    r = (b & d) | (c & ~d);
            2'd2:    r = b ^ c ^ d;
            default: r = c ^ (b | ~d);
        endcase
        return r;
    endfunction

    // Message word index; only the low four bits of the round matter modulo 16.
    function automatic logic [3:0] md5_g(input logic [5:0] i);
        logic [3:0] r;
        unique case (i[5:4])
            2'd0:    r = i[3:0];
            2'd1:    r = i[3:0] * 4'd5 + 4'd1;
            2'd2:    r = i[3:0] * 4'd3 + 4'd5;
            default: r = i[3:0] * 4'd7;
        endcase
        return r;
    endfunction

    // Padded block words: only M0, M1 (message), M2 (0x80) and M14 (bit length) are non-zero.
    function automatic logic [31:0] word_at(input logic [3:0] g, input logic [63:0] m);
        logic [31:0] r;
        r = 32'h0;
        case (g)
            4'd0:  r = bswap(m[63:32]);
            4'd1:  r = bswap(m[31:0]);
            4'd2:  r = 32'h0000_0080;
            4'd14: r = 32'h0000_0040;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [63:0]   msg_q, msg_d;
    logic [31:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [5:0]    rnd_q, rnd_d;
    logic [127:0]  digest_q, digest_d;

    // Round datapath results after UNROLL rounds.
    logic [31:0]   rnd_a, rnd_b, rnd_c, rnd_d_w;
    logic [31:0]   rnd_tmp;
    logic [5:0]    rnd_idx;

    always_comb begin
        rnd_a   = a_q;
        rnd_b   = b_q;
        rnd_c   = c_q;
        rnd_d_w = d_q;
        rnd_tmp = 32'h0;
        rnd_idx = rnd_q;
        for (int unsigned k = 0; k < UNROLL; k++) begin
            rnd_idx = rnd_q + 6'(k);
            rnd_tmp = rnd_a + md5_f(rnd_idx[5:4], rnd_b, rnd_c, rnd_d_w) + KTab[rnd_idx]
                    + word_at(md5_g(rnd_idx), msg_q);
            rnd_a   = rnd_d_w;
            rnd_d_w = rnd_c;
            rnd_c   = rnd_b;
            rnd_b   = rnd_b + rotl(rnd_tmp, STab[{rnd_idx[5:4], rnd_idx[1:0]}]);
        end
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        rnd_d    = rnd_q;
        digest_d = digest_q;

        unique case (state_q)
            StIdle, StFinish: begin
                if (start) begin
                    state_d = StRound;
                    msg_d   = msg;
                    a_d     = InitA;
                    b_d     = InitB;
                    c_d     = InitC;
                    d_d     = InitD;
                    rnd_d   = 6'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRound: begin
                a_d   = rnd_a;
                b_d   = rnd_b;
                c_d   = rnd_c;
                d_d   = rnd_d_w;
                rnd_d = rnd_q + 6'(UNROLL);
                if (rnd_q == LastRnd) begin
                    state_d  = StFinish;
                    digest_d = {bswap(rnd_a + InitA), bswap(rnd_b + InitB),
                                bswap(rnd_c + InitC), bswap(rnd_d_w + InitD)};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            msg_q    <= 64'h0;
            a_q      <= InitA;
            b_q      <= InitB;
            c_q      <= InitC;
            d_q      <= InitD;
            rnd_q    <= 6'd0;
            digest_q <= 128'h0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            rnd_q    <= rnd_d;
            digest_q <= digest_d;
        end
    end

    assign busy   = (state_q == StRound);
    assign done   = (state_q == StFinish);
    assign digest = digest_q;

endmodule

// File: tb/tb_md5_digit_core.sv
// Bench for md5_digit_core: three instances (UNROLL 1, 2, 4) driven with the same requests,
// digests compared against known vectors and a software MD5 model.
module tb_md5_digit_core;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   start_v;
    logic [63:0]  msg_v [3];
    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [127:0] digest_v [3];

    int n_tests = 0;
    int n_fail  = 0;

    localparam int Unroll [3] = '{1, 2, 4};
    localparam logic [127:0] Dig1234 = 128'h25d55ad283aa400af464c76d713c07ad;
    localparam logic [127:0] Dig1111 = 128'h1bbd886460827015e5d605ed44252251;

    always #5 clk = ~clk;

    md5_digit_core #(.UNROLL(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .msg(msg_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .digest(digest_v[0])
    );
    md5_digit_core #(.UNROLL(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .msg(msg_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .digest(digest_v[1])
    );
    md5_digit_core #(.UNROLL(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .msg(msg_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .digest(digest_v[2])
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Textbook MD5 of one padded 8-byte message; K derived from |sin(i+1)| * 2^32.
    function automatic logic [127:0] md5_ref(input logic [63:0] m);
        logic [7:0]  blk [64];
        logic [31:0] w [16];
        int          sh [16];
        logic [31:0] a, b, c, d, f, tmp, kk;
        int          g, s;
        real         r;
        sh = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < 8; i++) blk[i] = m[63 - 8 * i -: 8];
        blk[8]  = 8'h80;
        blk[56] = 8'h40;
        for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i;                end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16;    end
            endcase
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kk  = 32'(longint'($floor(r * 4294967296.0)));
            s   = sh[(i / 16) * 4 + (i % 4)];
            tmp = a + f + kk + w[g];
            a = d; d = c; c = b;
            b = b + ((tmp << s) | (tmp >> (32 - s)));
        end
        return {bswap(a + 32'h67452301), bswap(b + 32'hefcdab89),
                bswap(c + 32'h98badcfe), bswap(d + 32'h10325476)};
    endfunction

    // Start all three instances with m; optionally pulse start again with poke_m at cycle poke_cyc.
    task automatic hash_all(input string tag, input logic [63:0] m, input logic [127:0] exp,
                            input int poke_cyc, input logic [63:0] poke_m);
        int first [3];
        int cnt [3];
        @(negedge clk);
        start_v = 3'b111;
        for (int k = 0; k < 3; k++) msg_v[k] = m;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        for (int k = 0; k < 3; k++) begin first[k] = 0; cnt[k] = 0; end
        for (int n = 1; n <= 80; n++) begin
            if (n == poke_cyc) begin
                start_v = 3'b111;
                for (int k = 0; k < 3; k++) msg_v[k] = poke_m;
            end else begin
                start_v = 3'b000;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) begin
                    cnt[k]++;
                    if (first[k] == 0) first[k] = n;
                end
            end
        end
        start_v = 3'b000;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s_latency_u%0d", tag, Unroll[k]), 128'(first[k] + 1),
                     128'(64 / Unroll[k] + 1));
            check_eq($sformatf("%s_done_cycles_u%0d", tag, Unroll[k]), 128'(cnt[k]), 128'd1);
            check_eq($sformatf("%s_digest_u%0d", tag, Unroll[k]), digest_v[k], exp);
        end
    endtask

    // Wait for done on the UNROLL=1 instance; returns 0 if it never came.
    task automatic wait_done1(output int n_seen);
        n_seen = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                n_seen = n;
                break;
            end
        end
    endtask

    initial begin
        logic [63:0] m;
        int          n1;
        int          dcnt;

        reset_n = 1'b0;
        start_v = 3'b000;
        for (int k = 0; k < 3; k++) msg_v[k] = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_busy_u%0d", Unroll[k]), 128'(busy_v[k]), 128'd0);
            check_eq($sformatf("rst_done_u%0d", Unroll[k]), 128'(done_v[k]), 128'd0);
            check_eq($sformatf("rst_digest_u%0d", Unroll[k]), digest_v[k], 128'd0);
        end

        hash_all("h12345678", "12345678", Dig1234, 0, 64'h0);
        hash_all("h11111111", "11111111", Dig1111, 0, 64'h0);
        // A second start mid-hash must be ignored.
        hash_all("ignore", "12345678", Dig1234, 5, "abcdefgh");

        // Back-to-back on the UNROLL=1 instance: start held in the done cycle.
        @(negedge clk);
        start_v[0] = 1'b1;
        msg_v[0]   = "12345678";
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done1(n1);
        check_eq("b2b_first_latency", 128'(n1 + 1), 128'd65);
        check_eq("b2b_first_digest", digest_v[0], Dig1234);
        start_v[0] = 1'b1;
        msg_v[0]   = "11111111";
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check_eq("b2b_busy_next", 128'(busy_v[0]), 128'd1);
        check_eq("b2b_done_next", 128'(done_v[0]), 128'd0);
        check_eq("b2b_digest_hold", digest_v[0], Dig1234);
        wait_done1(n1);
        check_eq("b2b_second_latency", 128'(n1 + 1), 128'd65);
        check_eq("b2b_second_digest", digest_v[0], Dig1111);
        repeat (2) @(posedge clk);

        // Reset mid-round, with a start presented on the reset edge.
        @(negedge clk);
        start_v = 3'b111;
        for (int k = 0; k < 3; k++) msg_v[k] = "12345678";
        @(posedge clk);
        #1;
        start_v = 3'b000;
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        start_v = 3'b111;
        @(negedge clk);
        reset_n = 1'b1;
        start_v = 3'b000;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("midrst_busy_u%0d", Unroll[k]), 128'(busy_v[k]), 128'd0);
            check_eq($sformatf("midrst_done_u%0d", Unroll[k]), 128'(done_v[k]), 128'd0);
            check_eq($sformatf("midrst_digest_u%0d", Unroll[k]), digest_v[k], 128'd0);
        end
        dcnt = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) if (done_v[k]) dcnt++;
        end
        check_eq("midrst_no_done", 128'(dcnt), 128'd0);
        hash_all("after_rst", "12345678", Dig1234, 0, 64'h0);

        for (int t = 0; t < 12; t++) begin
            m = {$urandom(), $urandom()};
            hash_all($sformatf("rand%0d_%h", t, m), m, md5_ref(m), 0, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
